// File: rtl/display_word_formatter.sv
// Latches a 16-bit word for the six-digit board display, either as hex (one cycle)
// or as unsigned decimal via a sequential double-dabble conversion.
//
// state  | meaning
// IDLE   | committed digits stable, no conversion running
// SHIFT  | double-dabble: add-3 correction then one left shift per cycle, 16 cycles
// COMMIT | conversion done; BCD result is copied to the outputs on this edge
module display_word_formatter #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                dec_mode,
  input  logic                lzb_en,
  input  logic                disp_en,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     blank,
  output logic                busy,
  output logic                upd
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t       state;
  logic [15:0]  shreg;
  logic [19:0]  bcd;
  logic [19:0]  bcd_adj;
  logic [3:0]   cnt;
  logic         mode_dec;
  logic         seen_nz;
  int           n_active;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // cnt is a down-counter: loaded with 15, the shift taken at zero is the 16th.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      digits   <= '0;
      mode_dec <= 1'b0;
      busy     <= 1'b0;
      upd      <= 1'b0;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      upd <= 1'b0;
      if (wr_en && !dec_mode) begin
        digits   <= {8'h00, wr_data};
        mode_dec <= 1'b0;
        upd      <= 1'b1;
        busy     <= 1'b0;
        state    <= IDLE;
      end else if (wr_en) begin
        shreg <= wr_data;
        bcd   <= '0;
        cnt   <= 4'd15;
        busy  <= 1'b1;
        state <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            {bcd, shreg} <= {bcd_adj[18:0], shreg, 1'b0};
            if (cnt == 4'd0) state <= COMMIT;
            else             cnt   <= cnt - 4'd1;
          end
          COMMIT: begin
            digits   <= {4'h0, bcd};
            mode_dec <= 1'b1;
            upd      <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Scan from the top digit down; a digit is lz-blanked until the first non-zero one.
  always_comb begin
    blank    = '1;
    seen_nz  = 1'b0;
    n_active = mode_dec ? 5 : 4;
    if (disp_en) begin
      for (int k = NDIG - 1; k >= 0; k--) begin
        if (k < n_active) begin
          if (digits[4*k +: 4] != 4'h0) seen_nz = 1'b1;
          blank[k] = lzb_en && !seen_nz && (k != 0);
        end
      end
    end
  end

endmodule
